// File: rtl/bram_r1_w1_pipe.sv
// 1R/1W block RAM: RD_LATENCY-deep read pipeline, selectable collision mode, optional post-reset zero sweep.
// Read data appears RD_LATENCY cycles after acceptance; there is no backpressure, and requests are dropped while ready is low.
module bram_r1_w1_pipe #(
    parameter int ADDR_WIDTH     = 4,
    parameter int ELEMENT_WIDTH  = 16,
    parameter int RD_LATENCY     = 1,
    parameter int READ_FIRST     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_addr_en,
    input  logic [ADDR_WIDTH-1:0]    p0_addr_data,
    input  logic                     p0_rd_en,
    output logic [ELEMENT_WIDTH-1:0] p0_rd_data,
    output logic                     p0_rd_valid,
    input  logic                     p1_addr_en,
    input  logic [ADDR_WIDTH-1:0]    p1_addr_data,
    input  logic                     p1_wr_en,
    input  logic [ELEMENT_WIDTH-1:0] p1_wr_data,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    clr_we;

    logic [ELEMENT_WIDTH-1:0] mem [DEPTH];
    logic                     mem_we;
    logic [ADDR_WIDTH-1:0]    mem_waddr;
    logic [ELEMENT_WIDTH-1:0] mem_wdata;
    logic                     rd_acc, wr_acc, collide;

    logic [ELEMENT_WIDTH-1:0] pipe_dat_q [RD_LATENCY];
    logic [ELEMENT_WIDTH-1:0] pipe_dat_d [RD_LATENCY];
    logic [RD_LATENCY-1:0]    pipe_vld_q, pipe_vld_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Next state: the sweep parks on the last address instead of wrapping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // FSM outputs; ready is registered off the next state so it rises with the last clear write
    always_comb begin
        clr_we  = (state_q == ST_CLEAR);
        ready_d = (state_d == ST_READY);
    end

    assign ready = ready_q;

    always_comb begin
        rd_acc    = ready_q & p0_addr_en & p0_rd_en;
        wr_acc    = ready_q & p1_addr_en & p1_wr_en;
        collide   = (READ_FIRST == 0) && wr_acc && (p1_addr_data == p0_addr_data);
        mem_we    = clr_we | wr_acc;
        mem_waddr = clr_we ? cnt_q : p1_addr_data;
        mem_wdata = clr_we ? '0 : p1_wr_data;
    end

    // Array has no reset: contents survive an async reset until the sweep reaches them
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Each stage only loads when a valid word moves in, so the output holds between results
    always_comb begin
        for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_dat_d[i] = pipe_dat_q[i];
        end
        pipe_vld_d    = '0;
        pipe_vld_d[0] = rd_acc;
        if (rd_acc) begin
            pipe_dat_d[0] = collide ? p1_wr_data : mem[p0_addr_data];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            if (pipe_vld_q[i-1]) begin
                pipe_dat_d[i] = pipe_dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_dat_q[i] <= '0;
            end
            pipe_vld_q <= '0;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
            pipe_vld_q <= pipe_vld_d;
        end
    end

    assign p0_rd_data  = pipe_dat_q[RD_LATENCY-1];
    assign p0_rd_valid = pipe_vld_q[RD_LATENCY-1];

endmodule

// File: tb/tb_bram_r1_w1_pipe.sv
// Directed bench: three instances sharing stimulus (lat3/read-first/clear, lat2/bypass/clear, lat1/read-first/no-clear).
module tb_bram_r1_w1_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_addr_en = 1'b0, p0_rd_en = 1'b0;
    logic [3:0]  p0_addr_data = '0;
    logic        p1_addr_en = 1'b0, p1_wr_en = 1'b0;
    logic [3:0]  p1_addr_data = '0;
    logic [15:0] p1_wr_data = '0;

    logic [15:0] a_dat, b_dat, c_dat;
    logic        a_vld, b_vld, c_vld, a_rdy, b_rdy, c_rdy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [15:0] qa_d[$], qb_d[$], qc_d[$];
    int          qa_c[$], qb_c[$], qc_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_r1_w1_pipe #(.ADDR_WIDTH(4), .ELEMENT_WIDTH(16), .RD_LATENCY(3), .READ_FIRST(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(rst), .p0_addr_en(p0_addr_en), .p0_addr_data(p0_addr_data), .p0_rd_en(p0_rd_en),
        .p0_rd_data(a_dat), .p0_rd_valid(a_vld), .p1_addr_en(p1_addr_en), .p1_addr_data(p1_addr_data),
        .p1_wr_en(p1_wr_en), .p1_wr_data(p1_wr_data), .ready(a_rdy));

    bram_r1_w1_pipe #(.ADDR_WIDTH(4), .ELEMENT_WIDTH(16), .RD_LATENCY(2), .READ_FIRST(0), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst), .p0_addr_en(p0_addr_en), .p0_addr_data(p0_addr_data), .p0_rd_en(p0_rd_en),
        .p0_rd_data(b_dat), .p0_rd_valid(b_vld), .p1_addr_en(p1_addr_en), .p1_addr_data(p1_addr_data),
        .p1_wr_en(p1_wr_en), .p1_wr_data(p1_wr_data), .ready(b_rdy));

    bram_r1_w1_pipe #(.ADDR_WIDTH(4), .ELEMENT_WIDTH(16), .RD_LATENCY(1), .READ_FIRST(1), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .rst(rst), .p0_addr_en(p0_addr_en), .p0_addr_data(p0_addr_data), .p0_rd_en(p0_rd_en),
        .p0_rd_data(c_dat), .p0_rd_valid(c_vld), .p1_addr_en(p1_addr_en), .p1_addr_data(p1_addr_data),
        .p1_wr_en(p1_wr_en), .p1_wr_data(p1_wr_data), .ready(c_rdy));

    // Capture every valid result together with the edge count it followed
    always @(negedge clk) begin
        if (a_vld) begin qa_d.push_back(a_dat); qa_c.push_back(cyc); end
        if (b_vld) begin qb_d.push_back(b_dat); qb_c.push_back(cyc); end
        if (c_vld) begin qc_d.push_back(c_dat); qc_c.push_back(cyc); end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        p0_addr_en = 1'b0; p0_rd_en = 1'b0; p1_addr_en = 1'b0; p1_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        p0_addr_en = 1'b1; p0_rd_en = 1'b1; p0_addr_data = a;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        p1_addr_en = 1'b1; p1_wr_en = 1'b1; p1_addr_data = a; p1_wr_data = d;
    endtask

    task automatic clr_q();
        qa_d.delete(); qb_d.delete(); qc_d.delete();
        qa_c.delete(); qb_c.delete(); qc_c.delete();
    endtask

    task automatic test_reset();
        step();
        n_cmp++;
        if ({a_vld, a_rdy, b_vld, b_rdy, c_vld, c_rdy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 000000", {a_vld, a_rdy, b_vld, b_rdy, c_vld, c_rdy});
        end
        n_cmp++;
        if ({a_dat, b_dat, c_dat} !== 48'h0) begin
            n_bad++; $display("FAIL reset_data got %h want 0", {a_dat, b_dat, c_dat});
        end
    endtask

    task automatic test_clear_sweep();
        int la = 0, lb = 0, lc = 0;
        rst = 1'b1;
        for (int k = 0; k < 100 && !(a_rdy && b_rdy); k++) begin
            if (!a_rdy) la++;
            if (!b_rdy) lb++;
            if (!c_rdy) lc++;
            step();
        end
        n_cmp++; if (la != 16) begin n_bad++; $display("FAIL sweep_len_a got %0d want 16", la); end
        n_cmp++; if (lb != 16) begin n_bad++; $display("FAIL sweep_len_b got %0d want 16", lb); end
        n_cmp++; if (lc != 1)  begin n_bad++; $display("FAIL noclear_ready_c got %0d want 1", lc); end
        clr_q();
        for (int i = 0; i < 16; i++) begin rd(4'(i)); step(); end
        idle();
        repeat (6) step();
        n_cmp++; if (qa_d.size() != 16) begin n_bad++; $display("FAIL sweep_cnt_a got %0d want 16", qa_d.size()); end
        n_cmp++; if (qb_d.size() != 16) begin n_bad++; $display("FAIL sweep_cnt_b got %0d want 16", qb_d.size()); end
        if (qa_d.size() == 16 && qb_d.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (qa_d[i] !== 16'h0 || qb_d[i] !== 16'h0) begin
                    n_bad++; $display("FAIL sweep_zero[%0d] got a=%h b=%h want 0", i, qa_d[i], qb_d[i]);
                end
            end
        end
    endtask

    task automatic test_latency();
        int r;
        clr_q();
        wr(4'd3, 16'hBEEF);
        step();
        idle();
        rd(4'd3);
        r = cyc + 1;
        step();
        idle();
        repeat (6) step();
        n_cmp++;
        if (qa_d.size() != 1 || qa_c[0] != r + 2 || qa_d[0] !== 16'hBEEF) begin
            n_bad++; $display("FAIL lat3_a got n=%0d cyc=%0d d=%h want n=1 cyc=%0d d=beef", qa_d.size(), qa_c[0], qa_d[0], r + 2);
        end
        n_cmp++;
        if (qb_d.size() != 1 || qb_c[0] != r + 1 || qb_d[0] !== 16'hBEEF) begin
            n_bad++; $display("FAIL lat2_b got n=%0d cyc=%0d d=%h want n=1 cyc=%0d d=beef", qb_d.size(), qb_c[0], qb_d[0], r + 1);
        end
        n_cmp++;
        if (qc_d.size() != 1 || qc_c[0] != r || qc_d[0] !== 16'hBEEF) begin
            n_bad++; $display("FAIL lat1_c got n=%0d cyc=%0d d=%h want n=1 cyc=%0d d=beef", qc_d.size(), qc_c[0], qc_d[0], r);
        end
    endtask

    task automatic test_collision();
        logic [15:0] ea[3];
        logic [15:0] eb[3];
        ea = '{16'h0A0A, 16'h1234, 16'h5555};
        eb = '{16'h1234, 16'h1234, 16'h5555};
        clr_q();
        wr(4'd5, 16'h0A0A); step(); idle();
        rd(4'd5); wr(4'd5, 16'h1234); step(); idle();
        rd(4'd5); step(); idle();
        wr(4'd5, 16'h5555); step(); idle();
        rd(4'd5); step(); idle();
        repeat (6) step();
        n_cmp++; if (qa_d.size() != 3) begin n_bad++; $display("FAIL coll_cnt_a got %0d want 3", qa_d.size()); end
        n_cmp++; if (qb_d.size() != 3) begin n_bad++; $display("FAIL coll_cnt_b got %0d want 3", qb_d.size()); end
        n_cmp++; if (qc_d.size() != 3) begin n_bad++; $display("FAIL coll_cnt_c got %0d want 3", qc_d.size()); end
        if (qa_d.size() == 3 && qb_d.size() == 3 && qc_d.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (qa_d[i] !== ea[i]) begin n_bad++; $display("FAIL coll_a[%0d] got %h want %h", i, qa_d[i], ea[i]); end
                n_cmp++; if (qb_d[i] !== eb[i]) begin n_bad++; $display("FAIL coll_b[%0d] got %h want %h", i, qb_d[i], eb[i]); end
                n_cmp++; if (qc_d[i] !== ea[i]) begin n_bad++; $display("FAIL coll_c[%0d] got %h want %h", i, qc_d[i], ea[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        clr_q();
        for (int i = 0; i < 8; i++) begin wr(4'(i), 16'(i * 2)); step(); end
        idle();
        r0 = cyc + 1;
        for (int i = 0; i < 8; i++) begin rd(4'(i)); step(); end
        idle();
        repeat (6) step();
        n_cmp++; if (qb_d.size() != 8) begin n_bad++; $display("FAIL b2b_cnt_b got %0d want 8", qb_d.size()); end
        n_cmp++; if (qa_d.size() != 8) begin n_bad++; $display("FAIL b2b_cnt_a got %0d want 8", qa_d.size()); end
        if (qb_d.size() == 8 && qa_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (qb_d[i] !== 16'(i * 2) || qb_c[i] != r0 + 1 + i) begin
                    n_bad++; $display("FAIL b2b_b[%0d] got d=%h cyc=%0d want d=%h cyc=%0d", i, qb_d[i], qb_c[i], 16'(i * 2), r0 + 1 + i);
                end
                n_cmp++;
                if (qa_d[i] !== 16'(i * 2)) begin
                    n_bad++; $display("FAIL b2b_a[%0d] got %h want %h", i, qa_d[i], 16'(i * 2));
                end
            end
        end
    endtask

    task automatic test_gated_enables();
        clr_q();
        p0_rd_en = 1'b1; p0_addr_en = 1'b0; p0_addr_data = 4'd4;
        p1_wr_en = 1'b1; p1_addr_en = 1'b0; p1_addr_data = 4'd4; p1_wr_data = 16'hFFFF;
        repeat (3) step();
        idle();
        repeat (5) step();
        n_cmp++;
        if (qa_d.size() + qb_d.size() + qc_d.size() != 0) begin
            n_bad++; $display("FAIL gated_no_valid got %0d results want 0", qa_d.size() + qb_d.size() + qc_d.size());
        end
        rd(4'd4); step(); idle();
        repeat (6) step();
        n_cmp++;
        if (qa_d.size() != 1 || qa_d[0] !== 16'h0008) begin n_bad++; $display("FAIL gated_mem_a got %h want 0008", qa_d[0]); end
        n_cmp++;
        if (qb_d.size() != 1 || qb_d[0] !== 16'h0008) begin n_bad++; $display("FAIL gated_mem_b got %h want 0008", qb_d[0]); end
        n_cmp++;
        if (qc_d.size() != 1 || qc_d[0] !== 16'h0008) begin n_bad++; $display("FAIL gated_mem_c got %h want 0008", qc_d[0]); end
    endtask

    task automatic test_reset_mid_clear();
        int la = 0, lb = 0;
        wr(4'd12, 16'hFFFF); step(); idle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({a_dat, b_dat, a_vld, b_vld, a_rdy, b_rdy} !== 36'h0) begin
            n_bad++; $display("FAIL async_reset got %h want 0", {a_dat, b_dat, a_vld, b_vld, a_rdy, b_rdy});
        end
        step();
        rst = 1'b1;
        repeat (7) step();
        n_cmp++; if (a_rdy !== 1'b0 || b_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_sweep_ready got %b%b want 00", a_rdy, b_rdy); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        clr_q();
        for (int k = 0; k < 100 && !(a_rdy && b_rdy); k++) begin
            if (!a_rdy) la++;
            if (!b_rdy) lb++;
            idle();
            if (k == 3) rd(4'd5);
            if (k == 10) begin rd(4'd12); wr(4'd2, 16'hABCD); end
            step();
        end
        idle();
        n_cmp++; if (la != 16) begin n_bad++; $display("FAIL resweep_len_a got %0d want 16", la); end
        n_cmp++; if (lb != 16) begin n_bad++; $display("FAIL resweep_len_b got %0d want 16", lb); end
        n_cmp++;
        if (qa_d.size() + qb_d.size() != 0) begin
            n_bad++; $display("FAIL clear_reads_dropped got %0d results want 0", qa_d.size() + qb_d.size());
        end
        clr_q();
        rd(4'd12); step();
        rd(4'd2);  step();
        idle();
        repeat (6) step();
        n_cmp++;
        if (qa_d.size() != 2 || qa_d[0] !== 16'h0 || qa_d[1] !== 16'h0) begin
            n_bad++; $display("FAIL resweep_a got n=%0d %h %h want n=2 0 0", qa_d.size(), qa_d[0], qa_d[1]);
        end
        n_cmp++;
        if (qb_d.size() != 2 || qb_d[0] !== 16'h0 || qb_d[1] !== 16'h0) begin
            n_bad++; $display("FAIL resweep_b got n=%0d %h %h want n=2 0 0", qb_d.size(), qb_d[0], qb_d[1]);
        end
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_latency();
        test_collision();
        test_back_to_back();
        test_gated_enables();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
